// File: rtl/vga_timing_controller.sv
// vga_timing_controller: VGA raster timing generator; the vertical phase lives in the FSM state.
// All outputs are registered from the next-state values, so they share the counts' cycle and cannot glitch.
module vga_timing_controller #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic        clk_25MHz,
   input  logic        rst_n,
   input  logic        run,
   output logic [15:0] H_Count_Value,
   output logic [15:0] V_Count_Value,
   output logic        enable_V_Counter,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic        frame_start,
   output logic        busy
);
   localparam logic [15:0] H_LAST = 16'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [15:0] H_VIS  = 16'(H_VISIBLE);
   localparam logic [15:0] HS_BEG = 16'(H_VISIBLE + H_FRONT);
   localparam logic [15:0] HS_END = 16'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [15:0] V_LAST = 16'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [15:0] V_FP   = 16'(V_VISIBLE);
   localparam logic [15:0] V_SY   = 16'(V_VISIBLE + V_FRONT);
   localparam logic [15:0] V_BP   = 16'(V_VISIBLE + V_FRONT + V_SYNC);

   typedef enum logic [2:0] {IDLE, ACTIVE, FRONT, SYNC, BACK} state_t;

   state_t      state, state_n;
   logic [15:0] h_n, v_n;
   logic        en_n, hs_n, vs_n, vo_n, fs_n;

   always_comb begin
      state_n = state;
      h_n     = 16'd0;
      v_n     = 16'd0;
      if (state == IDLE) begin
         state_n = run ? ACTIVE : IDLE;
      end else begin
         h_n = (H_Count_Value == H_LAST) ? 16'd0 : H_Count_Value + 16'd1;
         v_n = V_Count_Value;
         if (H_Count_Value == H_LAST) begin
            v_n = (V_Count_Value == V_LAST) ? 16'd0 : V_Count_Value + 16'd1;
            if (v_n == V_FP)
               state_n = FRONT;
            else if (v_n == V_SY)
               state_n = SYNC;
            else if (v_n == V_BP)
               state_n = BACK;
            else if (v_n == 16'd0)
               state_n = run ? ACTIVE : IDLE;
         end
      end
      en_n = (state_n != IDLE) && (h_n == H_LAST);
      hs_n = !((state_n != IDLE) && (h_n >= HS_BEG) && (h_n < HS_END));
      vs_n = (state_n != SYNC);
      vo_n = (state_n == ACTIVE) && (h_n < H_VIS);
      fs_n = (state_n == ACTIVE) && (h_n == 16'd0) && (v_n == 16'd0);
   end

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         H_Count_Value    <= 16'd0;
         V_Count_Value    <= 16'd0;
         enable_V_Counter <= 1'b0;
         hsync            <= 1'b1;
         vsync            <= 1'b1;
         video_on         <= 1'b0;
         frame_start      <= 1'b0;
         busy             <= 1'b0;
      end else begin
         state            <= state_n;
         H_Count_Value    <= h_n;
         V_Count_Value    <= v_n;
         enable_V_Counter <= en_n;
         hsync            <= hs_n;
         vsync            <= vs_n;
         video_on         <= vo_n;
         frame_start      <= fs_n;
         busy             <= (state_n != IDLE);
      end
   end
endmodule

// File: tb/tb_vga_timing_controller.sv
// tb_vga_timing_controller: scoreboard bench for the VGA timing generator, run with a shrunken raster
// (25 x 15) so whole frames, end-of-frame run drops and mid-sync resets fit in a short simulation.
module tb_vga_timing_controller;
   localparam int HV = 16, HF = 2, HS = 4, HB = 3, HT = HV + HF + HS + HB;
   localparam int VV = 8, VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;
   localparam int LIM = 2 * HT * VT;

   logic        clk_25MHz = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic [15:0] H_Count_Value, V_Count_Value;
   logic        enable_V_Counter, hsync, vsync, video_on, frame_start, busy;
   logic [37:0] obs;
   logic [37:0] sb[$];
   int          total = 0;
   int          bad = 0;
   bit          m_busy = 1'b0;
   int          mh = 0;
   int          mv = 0;

   vga_timing_controller #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) dut (
      .clk_25MHz(clk_25MHz), .rst_n(rst_n), .run(run),
      .H_Count_Value(H_Count_Value), .V_Count_Value(V_Count_Value),
      .enable_V_Counter(enable_V_Counter), .hsync(hsync), .vsync(vsync),
      .video_on(video_on), .frame_start(frame_start), .busy(busy)
   );

   always #5 clk_25MHz = ~clk_25MHz;

   assign obs = {H_Count_Value, V_Count_Value, enable_V_Counter, hsync, vsync, video_on, frame_start, busy};

   // Expected outputs come straight from raster ranges, not from a phase state machine.
   function automatic logic [37:0] model_out();
      return {16'(mh), 16'(mv),
              m_busy && mh == HT - 1,
              !(m_busy && mh >= HV + HF && mh < HV + HF + HS),
              !(m_busy && mv >= VV + VF && mv < VV + VF + VS),
              m_busy && mv < VV && mh < HV,
              m_busy && mh == 0 && mv == 0,
              m_busy};
   endfunction

   task automatic tick();
      @(posedge clk_25MHz);
      if (!rst_n) begin
         m_busy = 1'b0; mh = 0; mv = 0;
      end else if (!m_busy) begin
         if (run) begin m_busy = 1'b1; mh = 0; mv = 0; end
      end else if (mh == HT - 1) begin
         mh = 0;
         if (mv == VT - 1) begin
            mv = 0;
            if (!run) m_busy = 1'b0;
         end else mv++;
      end else mh++;
      sb.push_back(model_out());
      #1;
   endtask

   task automatic test_reset();
      logic [37:0] e;
      rst_n = 1'b0; run = 1'b1;
      repeat (3) begin
         tick();
         e = sb.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL reset got=%h want=%h", obs, e); end
      end
      rst_n = 1'b1; run = 1'b0;
      repeat (3) begin
         tick();
         e = sb.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL idle_hold got=%h want=%h", obs, e); end
      end
   endtask

   task automatic test_frame();
      logic [37:0] e;
      int en_cnt = 0, vs_cnt = 0, fs0 = -1, fs1 = -1;
      run = 1'b1;
      for (int i = 0; i < HT * VT + 2; i++) begin
         tick();
         e = sb.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL frame cyc=%0d got=%h want=%h", i, obs, e); end
         if (i < HT * VT && enable_V_Counter) en_cnt++;
         if (i < HT * VT && !vsync) vs_cnt++;
         if (frame_start) begin if (fs0 < 0) fs0 = i; else if (fs1 < 0) fs1 = i; end
      end
      total++;
      if (en_cnt != VT) begin bad++; $display("FAIL en_pulses got=%0d want=%0d", en_cnt, VT); end
      total++;
      if (vs_cnt != VS * HT) begin bad++; $display("FAIL vsync_len got=%0d want=%0d", vs_cnt, VS * HT); end
      total++;
      if (fs0 != 0 || fs1 - fs0 != HT * VT) begin
         bad++; $display("FAIL fs_period got=%0d,%0d want=0,%0d", fs0, fs1, HT * VT);
      end
   endtask

   task automatic test_boundary();
      logic [37:0] e;
      int n = 0;
      while (!(H_Count_Value == 16'(HT - 1) && V_Count_Value == 16'(VV - 1)) && n < LIM) begin
         tick();
         e = sb.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL bnd_wait1 got=%h want=%h", obs, e); end
         n++;
      end
      tick();
      e = sb.pop_front(); total++;
      if ({H_Count_Value, V_Count_Value, video_on, busy} !== {16'd0, 16'(VV), 1'b0, 1'b1}) begin
         bad++; $display("FAIL bnd_front got=%h/%h vo=%b want=0/%h vo=0", H_Count_Value, V_Count_Value, video_on, VV);
      end
      n = 0;
      while (!(H_Count_Value == 16'(HT - 1) && V_Count_Value == 16'(VT - 1)) && n < LIM) begin
         tick();
         e = sb.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL bnd_wait2 got=%h want=%h", obs, e); end
         n++;
      end
      tick();
      e = sb.pop_front(); total++;
      if ({H_Count_Value, V_Count_Value, frame_start} !== {16'd0, 16'd0, 1'b1}) begin
         bad++; $display("FAIL bnd_wrap got=%h/%h fs=%b want=0/0 fs=1", H_Count_Value, V_Count_Value, frame_start);
      end
   endtask

   task automatic test_run_drop();
      logic [37:0] e, last;
      int n = 0;
      while (V_Count_Value != 16'd4 && n < LIM) begin
         tick();
         e = sb.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL drop_wait got=%h want=%h", obs, e); end
         n++;
      end
      run = 1'b0;
      last = obs;
      n = 0;
      while (busy && n < LIM) begin
         last = obs;
         tick();
         e = sb.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL drop_run got=%h want=%h", obs, e); end
         n++;
      end
      total++;
      if (last[37:6] !== {16'(HT - 1), 16'(VT - 1)} || busy !== 1'b0) begin
         bad++; $display("FAIL drop_end got=%h busy=%b want=%h busy=0", last[37:6], busy, {16'(HT - 1), 16'(VT - 1)});
      end
      repeat (10) begin
         tick();
         e = sb.pop_front(); total++;
         if (obs !== e || frame_start !== 1'b0) begin bad++; $display("FAIL drop_idle got=%h want=%h", obs, e); end
      end
   endtask

   task automatic test_end_drop();
      logic [37:0] e;
      int n = 0;
      run = 1'b1;
      while (!(H_Count_Value == 16'(HT - 1) && V_Count_Value == 16'(VT - 1)) && n < LIM) begin
         tick();
         e = sb.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL end_wait got=%h want=%h", obs, e); end
         n++;
      end
      run = 1'b0;
      repeat (2) begin
         tick();
         e = sb.pop_front(); total++;
         if (obs !== e || busy !== 1'b0) begin bad++; $display("FAIL end_idle got=%h want=%h", obs, e); end
      end
      run = 1'b1;
      tick();
      e = sb.pop_front(); total++;
      if (obs !== e || frame_start !== 1'b1) begin bad++; $display("FAIL end_restart got=%h want=%h", obs, e); end
   endtask

   task automatic test_async_reset();
      logic [37:0] e;
      int n = 0;
      while (!(H_Count_Value == 16'(20) && V_Count_Value == 16'(VV + VF + 1)) && n < LIM) begin
         tick();
         e = sb.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL ar_wait got=%h want=%h", obs, e); end
         n++;
      end
      total++;
      if (vsync !== 1'b0) begin bad++; $display("FAIL ar_in_sync got vsync=%b want=0", vsync); end
      rst_n = 1'b0;
      #2;
      m_busy = 1'b0; mh = 0; mv = 0;
      e = model_out(); total++;
      if (obs !== e) begin bad++; $display("FAIL ar_immediate got=%h want=%h", obs, e); end
      tick();
      e = sb.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL ar_held got=%h want=%h", obs, e); end
      rst_n = 1'b1;
      for (int i = 0; i < HT * VT + 3; i++) begin
         tick();
         e = sb.pop_front(); total++;
         if (obs !== e) begin bad++; $display("FAIL ar_restart cyc=%0d got=%h want=%h", i, obs, e); end
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_boundary();
      test_run_drop();
      test_end_drop();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vga_timing_controller.md
VGA_TIMING_CONTROLLER -- requirements
Module: vga_timing_controller

Interface
REQ-001 Parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in clocks; H_TOTAL = sum of the four horizontal parameters = 800.
REQ-005 Parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 Parameter V_BACK, default 33, vertical back porch in lines; V_TOTAL = sum of the four vertical parameters = 525.
REQ-009 clk_25MHz  input  1  pixel clock; the single clock; all state updates on its rising edge.
REQ-010 rst_n  input  1  reset, asynchronous and active-low.
REQ-011 run  input  1  level request to generate frames.
REQ-012 H_Count_Value  output  16  horizontal position, 0..H_TOTAL-1.
REQ-013 V_Count_Value  output  16  vertical position, 0..V_TOTAL-1.
REQ-014 enable_V_Counter  output  1  one-clock line-advance strobe.
REQ-015 hsync  output  1  horizontal sync, active-low.
REQ-016 vsync  output  1  vertical sync, active-low.
REQ-017 video_on  output  1  pixel is in the visible area.
REQ-018 frame_start  output  1  one-clock strobe at the first pixel of a frame.
REQ-019 busy  output  1  high whenever the state is not IDLE.

Function
REQ-020 States: IDLE, ACTIVE, FRONT, SYNC, BACK; vertical phase is tracked by state, horizontal position by H_Count_Value.
REQ-021 In IDLE both counts hold 0, all strobes are 0, hsync=1, vsync=1, video_on=0, busy=0.
REQ-022 IDLE with run=1 goes to ACTIVE at the next edge with H=0, V=0; frame_start=1 for exactly the first ACTIVE cycle (H=0, V=0).
REQ-023 When not IDLE, H_Count_Value increments by 1 per clock and wraps H_TOTAL-1 -> 0.
REQ-024 enable_V_Counter=1 exactly in cycles where H_Count_Value=H_TOTAL-1 and state is not IDLE; it is 0 otherwise.
REQ-025 In each cycle with enable_V_Counter=1, V_Count_Value increments by 1, or wraps V_TOTAL-1 -> 0.
REQ-026 Phase transitions occur on the same edge as the V update: ACTIVE->FRONT when V becomes V_VISIBLE (480), FRONT->SYNC at 490, SYNC->BACK at 492, BACK->ACTIVE on wrap to 0.
REQ-027 At the end of the frame (H=799, V=524), if run=0 the next state is IDLE instead of ACTIVE; run is sampled only at that cycle, so a mid-frame drop of run completes the current frame.
REQ-028 frame_start is 1 on every first cycle of ACTIVE with V=0.
REQ-029 hsync=0 when not IDLE and H is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751]; hsync=1 otherwise.
REQ-030 vsync=0 exactly when state=SYNC (V in 490..491, all H); vsync=1 otherwise.
REQ-031 video_on=1 when state=ACTIVE and H<H_VISIBLE; it is 0 otherwise.
REQ-032 All outputs are derived from registered state or counts with zero added latency (the same cycle as the counts), and are glitch-free at the edge.
REQ-033 Counts never exceed H_TOTAL-1 or V_TOTAL-1; count widths are 16 bits with zero-extension.

Reset
REQ-034 rst_n=0 asynchronously forces IDLE, counts=0, hsync=1, vsync=1, all strobes 0 and video_on=0, including mid-frame.
REQ-035 After rst_n rises, the first transition out of IDLE requires run=1 sampled at a clock edge.

Verification
REQ-036 Reset release, run=1 -> frame_start at H=0,V=0; video_on=1 for H 0..639; hsync low for 656..751; enable_V_Counter high at H=799 only.
REQ-037 Full frame -> 525 enable_V_Counter pulses; vsync low for exactly 1600 clocks (V 490..491); 420000 clocks between frame_start pulses.
REQ-038 Drop run at V=100 -> frame completes through V=524,H=799, then IDLE; busy=0; no further frame_start.
REQ-039 run=0 at H=799,V=524 with run=1 elsewhere -> IDLE for at least one clock; re-enter ACTIVE only after run=1 is sampled.
REQ-040 Assert rst_n=0 at V=491,H=700 -> vsync and hsync go to 1 and counts to 0 immediately without a clock edge; after release, frames restart cleanly.
REQ-041 Boundary check: V=479,H=799 -> next cycle V=480, state FRONT, video_on=0; V=524,H=799 -> V=0, frame_start=1.
